// File: rtl/mul_seq_param.sv
// Iterative shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed mode multiplies magnitudes and applies the sign at completion.
module mul_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   res,
    output logic                 finish,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;
    logic             neg;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [PW-1:0]    partial_c;
    logic             last_c;

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1) in WIDTH bits.
    assign a_mag_c   = (sign_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign b_mag_c   = (sign_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;
    assign partial_c = PW'(mcand) << count;
    // All WIDTH iterations are done once count reaches WIDTH.
    assign last_c    = (count == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            res    <= '0;
            finish <= 1'b0;
            busy   <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag_c;
                        mplier <= b_mag_c;
                        neg    <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (last_c) begin
                        res    <= neg ? PW'(-acc) : acc;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + partial_c;
                        end
                        mplier <= mplier >> 1;
                        count  <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Scoreboard bench for mul_seq_param: a WIDTH=4 instance for the directed
// cases and a WIDTH=16 instance for the wide smoke case.
module tb_mul_seq_param;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start4, sign_mode4;
    logic [3:0]  a4, b4;
    logic [7:0]  res4;
    logic        finish4, busy4;
    logic        start16, sign_mode16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
    logic        finish16, busy16;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q4[$];
    exp_t q16[$];

    mul_seq_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sign_mode(sign_mode4),
        .a(a4), .b(b4), .res(res4), .finish(finish4), .busy(busy4)
    );

    mul_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sign_mode(sign_mode16),
        .a(a16), .b(b16), .res(res16), .finish(finish16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: a result is due on a known cycle; any other finish is spurious.
    always @(negedge clk) begin
        if (q4.size() > 0 && q4[0].due == cyc) begin
            chk("finish4_due", 64'(finish4), 64'd1);
            chk("res4", 64'(res4), q4[0].res);
            q4.delete(0);
        end else if (finish4) begin
            chk("finish4_spurious", 64'(finish4), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (q16.size() > 0 && q16[0].due == cyc) begin
            chk("finish16_due", 64'(finish16), 64'd1);
            chk("res16", 64'(res16), q16[0].res);
            q16.delete(0);
        end else if (finish16) begin
            chk("finish16_spurious", 64'(finish16), 64'd0);
        end
    end

    task automatic issue4(input logic sm, input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        sign_mode4 = sm;
        a4         = av;
        b4         = bv;
        start4     = 1'b1;
        e.res      = 64'(exp);
        e.due      = cyc + 1 + 5;
        if (push) q4.push_back(e);
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    task automatic issue16(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                           input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        sign_mode16 = sm;
        a16         = av;
        b16         = bv;
        start16     = 1'b1;
        e.res       = 64'(exp);
        e.due       = cyc + 1 + 17;
        q16.push_back(e);
        @(posedge clk);
        #1;
        start16 = 1'b0;
    endtask

    task automatic wait_done4(input string name);
        int n = 0;
        while (busy4 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_timeout"}, 64'(busy4), 64'd0);
    endtask

    task automatic wait_done16(input string name);
        int n = 0;
        while (busy16 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_timeout"}, 64'(busy16), 64'd0);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b0;
        start4      = 1'b0;
        sign_mode4  = 1'b0;
        a4          = '0;
        b4          = '0;
        start16     = 1'b0;
        sign_mode16 = 1'b0;
        a16         = '0;
        b16         = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res4", 64'(res4), 64'd0);
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_finish4", 64'(finish4), 64'd0);
        chk("rst_res16", 64'(res16), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        rst = 1'b1;

        // 15*15 unsigned with busy/finish timing
        issue4(1'b0, 4'd15, 4'd15, 8'hE1, 1'b1);
        chk("t1_busy_k", 64'(busy4), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_busy_k4", 64'(busy4), 64'd1);
        chk("t1_fin_k4", 64'(finish4), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_busy_k5", 64'(busy4), 64'd0);
        chk("t1_fin_k5", 64'(finish4), 64'd1);
        @(posedge clk);
        #1;
        chk("t1_fin_k6", 64'(finish4), 64'd0);
        chk("t1_hold", 64'(res4), 64'hE1);

        // signed cases
        issue4(1'b1, 4'b1000, 4'b1000, 8'h40, 1'b1);
        wait_done4("t2a");
        issue4(1'b1, 4'b1101, 4'b0101, 8'hF1, 1'b1);
        wait_done4("t2b");

        // zero operand keeps full latency; -1*-1
        issue4(1'b0, 4'd0, 4'd9, 8'h00, 1'b1);
        wait_done4("t3a");
        issue4(1'b1, 4'b1111, 4'b1111, 8'h01, 1'b1);
        wait_done4("t3b");

        // start while busy is ignored; operand changes have no effect
        issue4(1'b0, 4'd3, 4'd5, 8'h0F, 1'b1);
        @(posedge clk);
        #1;
        start4 = 1'b1;
        a4     = 4'd7;
        b4     = 4'd7;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4     = 4'd9;
        b4     = 4'd9;
        chk("t4_busy", 64'(busy4), 64'd1);
        wait_done4("t4");
        repeat (8) @(posedge clk);
        #1;
        chk("t4_res_hold", 64'(res4), 64'h0F);

        // back-to-back with start held high
        begin
            exp_t e;
            @(posedge clk);
            #1;
            sign_mode4 = 1'b0;
            a4         = 4'd2;
            b4         = 4'd3;
            start4     = 1'b1;
            e.res      = 64'h06;
            e.due      = cyc + 6;
            q4.push_back(e);
            repeat (6) @(posedge clk);
            #1;
            chk("t5_fin_first", 64'(finish4), 64'd1);
            a4    = 4'd6;
            b4    = 4'd7;
            e.res = 64'h2A;
            e.due = cyc + 6;
            q4.push_back(e);
            @(posedge clk);
            #1;
            start4 = 1'b0;
            chk("t5_busy_second", 64'(busy4), 64'd1);
            wait_done4("t5");
            @(posedge clk);
            #1;
            chk("t5_fin_after", 64'(finish4), 64'd0);
        end

        // reset in the middle of an operation
        issue4(1'b0, 4'd15, 4'd15, 8'hE1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_res", 64'(res4), 64'd0);
        chk("t6_busy", 64'(busy4), 64'd0);
        chk("t6_finish", 64'(finish4), 64'd0);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_finish_res", 64'(res4), 64'd0);
        issue4(1'b0, 4'd2, 4'd2, 8'h04, 1'b1);
        wait_done4("t6");

        // wide unsigned smoke test
        issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        chk("t7_busy", 64'(busy16), 64'd1);
        wait_done16("t7");

        repeat (10) @(posedge clk);
        #1;
        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("q16_drained", 64'(q16.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
